lnrv_boot_ctrl: RTL

//  Synthesizable boot/test controller that replaces bench-side firmware preload and end-of-test checking.
//  - Loads a little-endian byte stream into a word RAM through a gen_ram-style port (cs/we/wem/addr/wdata).
//  - Holds the core in reset while loading, then releases it after a fixed delay.
//  - Watches the core's end/pass flags (x26/x27 == 1) and reports pass, fail or watchdog timeout.
//  - Generalised over data width, RAM depth, reset delay, settle time and watchdog range.

---
 rtl/lnrv_boot_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lnrv_boot_ctrl.sv
// Boot/test controller: streams a little-endian byte image into a word RAM, holds the core
// in reset while loading and releases it after a fixed delay, then reports pass/fail/timeout.
// Latency: a RAM write appears the cycle after the handshake that completes a word (or the
// final byte). The byte stream is never stalled by the RAM; s_ready drops once all bytes
// have been accepted.
// Ports: clk/reset (sync, active-high); ld_start/ld_base/ld_bytes start a load;
//   s_valid/s_ready/s_data form the byte stream; ram_* is the gen_ram-style write port;
//   core_reset_n drives the core; end_flag/pass_flag come from the core;
//   wdog_limit is the run budget (0 = off); done/pass/fail/timeout report the result.
module lnrv_boot_ctrl #(
  parameter int P_DATA_WIDTH    = 32,
  parameter int P_ADDR_WIDTH    = 16,
  parameter int P_RST_DELAY     = 4,
  parameter int P_SETTLE_CYCLES = 50,
  parameter int P_WDOG_WIDTH    = 24,
  localparam int LP_NB          = P_DATA_WIDTH / 8,
  localparam int LP_BW          = P_ADDR_WIDTH + $clog2(LP_NB)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_start,
  input  logic [P_ADDR_WIDTH-1:0] ld_base,
  input  logic [LP_BW-1:0]        ld_bytes,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic [LP_NB-1:0]        ram_wem,
  output logic [P_ADDR_WIDTH-1:0] ram_addr,
  output logic [P_DATA_WIDTH-1:0] ram_wdata,
  output logic                    core_reset_n,
  input  logic                    end_flag,
  input  logic                    pass_flag,
  input  logic [P_WDOG_WIDTH-1:0] wdog_limit,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout
);

  localparam int LP_LW   = (LP_NB > 1) ? $clog2(LP_NB) : 1;
  localparam int LP_TMAX = (P_RST_DELAY > P_SETTLE_CYCLES) ? P_RST_DELAY : P_SETTLE_CYCLES;
  localparam int LP_TW   = $clog2(LP_TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DELAY, S_RUN, S_SETTLE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LP_BW-1:0]        cnt_q, cnt_d, bytes_q, bytes_d;
  logic [P_ADDR_WIDTH-1:0] base_q, woff_q;
  logic [LP_LW-1:0]        lane_q;
  logic [P_DATA_WIDTH-1:0] wbuf_q, buf_new;
  logic [LP_NB-1:0]        wmsk_q, msk_new;
  logic [LP_TW-1:0]        tmr_q;
  logic [P_WDOG_WIDTH-1:0] wdog_q;
  logic                    ld_acc, hs, last_lane, last_byte, wdog_hit;
  logic                    s_ready_d, crn_d, done_d, pass_d, fail_d, to_d;

  assign ld_acc    = ld_start && (state_q == S_IDLE || state_q == S_DONE);
  assign hs        = s_valid && s_ready;
  assign last_lane = (lane_q == LP_LW'(LP_NB - 1));
  assign last_byte = ((cnt_q + LP_BW'(1)) == bytes_q);
  assign wdog_hit  = (wdog_limit != '0) && (wdog_q == wdog_limit - P_WDOG_WIDTH'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (ld_start) state_d = (ld_bytes == '0) ? S_DELAY : S_LOAD;
      // cnt_q reaches bytes_q on the cycle the final word is on the RAM port,
      // so leaving here lets that write cycle complete first.
      S_LOAD:   if (cnt_q == bytes_q) state_d = S_DELAY;
      S_DELAY:  if (tmr_q == LP_TW'(P_RST_DELAY - 1)) state_d = S_RUN;
      S_RUN: begin
        if (end_flag)      state_d = S_SETTLE;   // end_flag beats a same-cycle expiry
        else if (wdog_hit) state_d = S_DONE;
      end
      S_SETTLE: if (tmr_q == LP_TW'(P_SETTLE_CYCLES - 1)) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    if (ld_acc) begin
      cnt_d   = '0;
      bytes_d = ld_bytes;
    end else if (hs) begin
      cnt_d = cnt_q + LP_BW'(1);
    end
    s_ready_d = (state_d == S_LOAD) && (cnt_d < bytes_d);
    crn_d     = (state_d == S_RUN) || (state_d == S_SETTLE) || (state_d == S_DONE);
    done_d    = (state_d == S_DONE);
    pass_d    = pass;
    fail_d    = fail;
    to_d      = timeout;
    if (ld_acc) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
      to_d   = 1'b0;
    end else if (state_q == S_RUN && state_d == S_DONE) begin
      fail_d = 1'b1;
      to_d   = 1'b1;
    end else if (state_q == S_SETTLE && state_d == S_DONE) begin
      pass_d = pass_flag;
      fail_d = !pass_flag;
    end
  end

  // Merge the incoming byte into the word being assembled
  always_comb begin
    buf_new = wbuf_q;
    msk_new = wmsk_q;
    for (int i = 0; i < LP_NB; i++) begin
      if (lane_q == LP_LW'(i)) begin
        buf_new[8*i +: 8] = s_data;
        msk_new[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready      <= 1'b0;
      core_reset_n <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_wem      <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      cnt_q        <= '0;
      bytes_q      <= '0;
      base_q       <= '0;
      woff_q       <= '0;
      lane_q       <= '0;
      wbuf_q       <= '0;
      wmsk_q       <= '0;
      tmr_q        <= '0;
      wdog_q       <= '0;
    end else begin
      s_ready      <= s_ready_d;
      core_reset_n <= crn_d;
      done         <= done_d;
      pass         <= pass_d;
      fail         <= fail_d;
      timeout      <= to_d;
      cnt_q        <= cnt_d;
      bytes_q      <= bytes_d;
      tmr_q        <= (state_d != state_q) ? '0 : tmr_q + LP_TW'(1);
      wdog_q       <= (state_q == S_RUN && state_d == S_RUN) ? wdog_q + P_WDOG_WIDTH'(1) : '0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      if (ld_acc) begin
        base_q <= ld_base;
        woff_q <= '0;
        lane_q <= '0;
        wbuf_q <= '0;
        wmsk_q <= '0;
      end else if (hs) begin
        if (last_lane || last_byte) begin
          // Unfilled lanes of a short final word stay zero and unmasked.
          ram_cs    <= 1'b1;
          ram_we    <= 1'b1;
          ram_addr  <= base_q + woff_q;
          ram_wdata <= buf_new;
          ram_wem   <= msk_new;
          wbuf_q    <= '0;
          wmsk_q    <= '0;
        end else begin
          wbuf_q <= buf_new;
          wmsk_q <= msk_new;
        end
        if (last_lane) begin
          lane_q <= '0;
          woff_q <= woff_q + P_ADDR_WIDTH'(1);
        end else begin
          lane_q <= lane_q + LP_LW'(1);
        end
      end
    end
  end

endmodule
